// File: rtl/arc_mem_ctrl_pkg.sv
// Shared types and constants for the ARC memory-side bus controller.
package arc_bus_pkg;

    localparam int unsigned ARC_WORD = 32;
    localparam int unsigned CNT_W    = 16;

    typedef enum logic [1:0] {
        StIdle,
        StWrWait,
        StRdWait,
        StDone
    } arc_state_e;

    function automatic int unsigned to_cyc(input int unsigned clk_freq,
                                           input int unsigned timeout_us);
        return clk_freq / 1000000 * timeout_us;
    endfunction

endpackage

// File: rtl/arc_mem_ctrl_if.sv
// Datapath-side and memory-side bus bundles for arc_mem_ctrl.
interface arc_cpu_if;
    import arc_bus_pkg::*;

    logic                cpu_req;
    logic                cpu_we;
    logic [ARC_WORD-1:0] cpu_addr;
    logic [ARC_WORD-1:0] cpu_wdata;
    logic [ARC_WORD-1:0] cpu_rdata;
    logic                cpu_ready;
    logic                cpu_err;

    modport master (output cpu_req, cpu_we, cpu_addr, cpu_wdata,
                    input  cpu_rdata, cpu_ready, cpu_err);
    modport slave  (input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
                    output cpu_rdata, cpu_ready, cpu_err);
endinterface

interface arc_mem_if;
    import arc_bus_pkg::*;

    logic [ARC_WORD-1:0] mem_addr;
    logic [ARC_WORD-1:0] mem_wdata;
    logic                mem_wr;
    logic                mem_rd;
    logic [ARC_WORD-1:0] mem_rdata;
    logic                w_ack;
    logic                r_ack;

    modport master (output mem_addr, mem_wdata, mem_wr, mem_rd,
                    input  mem_rdata, w_ack, r_ack);
    modport slave  (input  mem_addr, mem_wdata, mem_wr, mem_rd,
                    output mem_rdata, w_ack, r_ack);
endinterface

// File: rtl/arc_mem_ctrl_ack_sync.sv
// Two-flop synchronizer with rising-edge detect for an asynchronous ack level.
module ack_sync (
    input  logic clk,
    input  logic rst,
    input  logic ack_i,
    output logic rise_o
);

    logic sync1_q, sync2_q, prev_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            prev_q  <= 1'b0;
        end else begin
            sync1_q <= ack_i;
            sync2_q <= sync1_q;
            prev_q  <= sync2_q;
        end
    end

    assign rise_o = sync2_q & ~prev_q;

endmodule

// File: rtl/arc_mem_ctrl.sv
// Single-word load/store bus controller with ack handshake, timeout and alignment check.
module arc_mem_ctrl
    import arc_bus_pkg::*;
#(
    parameter int unsigned clk_freq   = 50000000,
    parameter int unsigned timeout_us = 10
) (
    input  logic      clk,
    input  logic      rst,
    arc_cpu_if.slave  cpu,
    arc_mem_if.master mem
);

    localparam int unsigned TO_CYC = to_cyc(clk_freq, timeout_us);
    localparam logic [CNT_W-1:0] CntLoad = CNT_W'(TO_CYC - 1);

    arc_state_e          state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [ARC_WORD-1:0] addr_q, addr_d;
    logic [ARC_WORD-1:0] wdata_q, wdata_d;
    logic [ARC_WORD-1:0] rdata_q, rdata_d;
    logic                err_d;
    logic                ready_q, err_q, wr_q, rd_q;
    logic                w_rise, r_rise;

    ack_sync u_w_sync (.clk(clk), .rst(rst), .ack_i(mem.w_ack), .rise_o(w_rise));
    ack_sync u_r_sync (.clk(clk), .rst(rst), .ack_i(mem.r_ack), .rise_o(r_rise));

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        err_d   = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (cpu.cpu_req) begin
                    addr_d  = cpu.cpu_addr;
                    wdata_d = cpu.cpu_wdata;
                    if (cpu.cpu_addr[1:0] != 2'b00) begin
                        state_d = StDone;
                        err_d   = 1'b1;
                    end else begin
                        state_d = cpu.cpu_we ? StWrWait : StRdWait;
                        cnt_d   = CntLoad;
                    end
                end
            end
            // Ack edge is checked before the counter so a coincident edge wins.
            StWrWait: begin
                if (w_rise) begin
                    state_d = StDone;
                end else if (cnt_q == '0) begin
                    state_d = StDone;
                    err_d   = 1'b1;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            StRdWait: begin
                if (r_rise) begin
                    state_d = StDone;
                    rdata_d = mem.mem_rdata;
                end else if (cnt_q == '0) begin
                    state_d = StDone;
                    err_d   = 1'b1;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            ready_q <= 1'b0;
            err_q   <= 1'b0;
            wr_q    <= 1'b0;
            rd_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            ready_q <= (state_d == StDone);
            err_q   <= err_d;
            wr_q    <= (state_d == StWrWait);
            rd_q    <= (state_d == StRdWait);
        end
    end

    assign cpu.cpu_rdata = rdata_q;
    assign cpu.cpu_ready = ready_q;
    assign cpu.cpu_err   = err_q;
    assign mem.mem_addr  = addr_q;
    assign mem.mem_wdata = wdata_q;
    assign mem.mem_wr    = wr_q;
    assign mem.mem_rd    = rd_q;

endmodule

// File: tb/tb_arc_mem_ctrl.sv
// Directed bench for arc_mem_ctrl: default-timeout instance A, 1 us timeout instance B.
module tb_arc_mem_ctrl;

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    arc_cpu_if a_cpu ();
    arc_mem_if a_mem ();
    arc_cpu_if b_cpu ();
    arc_mem_if b_mem ();

    arc_mem_ctrl #(.clk_freq(50000000), .timeout_us(10)) u_dut_a (
        .clk (clk),
        .rst (rst),
        .cpu (a_cpu),
        .mem (a_mem)
    );

    arc_mem_ctrl #(.clk_freq(50000000), .timeout_us(1)) u_dut_b (
        .clk (clk),
        .rst (rst),
        .cpu (b_cpu),
        .mem (b_mem)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    initial begin
        int n;
        int seen;
        checks = 0;
        errors = 0;
        rst = 1'b0;
        a_cpu.cpu_req = 0; a_cpu.cpu_we = 0; a_cpu.cpu_addr = '0; a_cpu.cpu_wdata = '0;
        a_mem.mem_rdata = '0; a_mem.w_ack = 0; a_mem.r_ack = 0;
        b_cpu.cpu_req = 0; b_cpu.cpu_we = 0; b_cpu.cpu_addr = '0; b_cpu.cpu_wdata = '0;
        b_mem.mem_rdata = '0; b_mem.w_ack = 0; b_mem.r_ack = 0;
        step; step;

        chk("rst_ready", a_cpu.cpu_ready, 0);
        chk("rst_err", a_cpu.cpu_err, 0);
        chk("rst_wr", a_mem.mem_wr, 0);
        chk("rst_rd", a_mem.mem_rd, 0);
        chk("rst_addr", a_mem.mem_addr, 0);
        chk("rst_wdata", a_mem.mem_wdata, 0);
        chk("rst_rdata", a_cpu.cpu_rdata, 0);
        rst = 1'b1;
        step;

        // Aligned store
        a_cpu.cpu_req = 1; a_cpu.cpu_we = 1;
        a_cpu.cpu_addr = 32'h0000_0100; a_cpu.cpu_wdata = 32'hDEAD_BEEF;
        step;
        a_cpu.cpu_req = 0;
        chk("st_wr", a_mem.mem_wr, 1);
        chk("st_rd", a_mem.mem_rd, 0);
        chk("st_addr", a_mem.mem_addr, 32'h0000_0100);
        chk("st_wdata", a_mem.mem_wdata, 32'hDEAD_BEEF);
        chk("st_ready_early", a_cpu.cpu_ready, 0);
        repeat (10) step;
        #4 a_mem.w_ack = 1;
        step;
        chk("st_ready_a", a_cpu.cpu_ready, 0);
        step;
        chk("st_ready_a1", a_cpu.cpu_ready, 0);
        chk("st_wr_a1", a_mem.mem_wr, 1);
        #4 a_mem.w_ack = 0;
        step;
        chk("st_ready", a_cpu.cpu_ready, 1);
        chk("st_err", a_cpu.cpu_err, 0);
        chk("st_wr_done", a_mem.mem_wr, 0);
        step;
        chk("st_ready_pulse", a_cpu.cpu_ready, 0);

        // Aligned load, with a wrong-type w_ack pulse ignored first
        a_mem.mem_rdata = 32'h1234_5678;
        a_cpu.cpu_req = 1; a_cpu.cpu_we = 0; a_cpu.cpu_addr = 32'h0000_0200;
        step;
        a_cpu.cpu_req = 0;
        chk("ld_rd", a_mem.mem_rd, 1);
        chk("ld_wr", a_mem.mem_wr, 0);
        chk("ld_addr", a_mem.mem_addr, 32'h0000_0200);
        #4 a_mem.w_ack = 1;
        repeat (3) step;
        #4 a_mem.w_ack = 0;
        repeat (2) step;
        chk("ld_wrong_ack_ready", a_cpu.cpu_ready, 0);
        chk("ld_wrong_ack_rd", a_mem.mem_rd, 1);
        #4 a_mem.r_ack = 1;
        step; step;
        #4 a_mem.r_ack = 0;
        step;
        chk("ld_ready", a_cpu.cpu_ready, 1);
        chk("ld_err", a_cpu.cpu_err, 0);
        chk("ld_rdata", a_cpu.cpu_rdata, 32'h1234_5678);
        chk("ld_rd_done", a_mem.mem_rd, 0);
        a_mem.mem_rdata = 32'h0BAD_0BAD;
        step;
        chk("ld_rdata_hold", a_cpu.cpu_rdata, 32'h1234_5678);

        // Misaligned load
        a_cpu.cpu_req = 1; a_cpu.cpu_we = 0; a_cpu.cpu_addr = 32'h0000_0102;
        step;
        a_cpu.cpu_req = 0;
        chk("mis_ready", a_cpu.cpu_ready, 1);
        chk("mis_err", a_cpu.cpu_err, 1);
        chk("mis_rd", a_mem.mem_rd, 0);
        step;
        chk("mis_ready_pulse", a_cpu.cpu_ready, 0);
        chk("mis_rd_after", a_mem.mem_rd, 0);
        chk("mis_rdata", a_cpu.cpu_rdata, 32'h1234_5678);

        // Stale ack held across completion into the next store
        a_cpu.cpu_req = 1; a_cpu.cpu_we = 1;
        a_cpu.cpu_addr = 32'h0000_0300; a_cpu.cpu_wdata = 32'hA5A5_A5A5;
        step;
        a_cpu.cpu_req = 0;
        #4 a_mem.w_ack = 1;
        step; step; step;
        chk("stale_first_ready", a_cpu.cpu_ready, 1);
        step;
        a_cpu.cpu_req = 1; a_cpu.cpu_we = 1;
        a_cpu.cpu_addr = 32'h0000_0304; a_cpu.cpu_wdata = 32'h1111_1111;
        step;
        a_cpu.cpu_addr = 32'h0000_0500; a_cpu.cpu_we = 0;
        step;
        a_cpu.cpu_req = 0;
        chk("stale_req_ign_addr", a_mem.mem_addr, 32'h0000_0304);
        chk("stale_req_ign_rd", a_mem.mem_rd, 0);
        seen = 0;
        repeat (5) begin step; if (a_cpu.cpu_ready) seen++; end
        chk("stale_no_complete", seen, 0);
        chk("stale_wr_held", a_mem.mem_wr, 1);
        #4 a_mem.w_ack = 0;
        repeat (3) step;
        chk("stale_fall_no_ready", a_cpu.cpu_ready, 0);
        #4 a_mem.w_ack = 1;
        step; step;
        #4 a_mem.w_ack = 0;
        step;
        chk("stale_ready", a_cpu.cpu_ready, 1);
        chk("stale_err", a_cpu.cpu_err, 0);
        repeat (4) step;

        // Instance B: successful load, then timeouts
        b_mem.mem_rdata = 32'hCAFE_F00D;
        b_cpu.cpu_req = 1; b_cpu.cpu_we = 0; b_cpu.cpu_addr = 32'h0000_0020;
        step;
        b_cpu.cpu_req = 0;
        step;
        #4 b_mem.r_ack = 1;
        step; step;
        #4 b_mem.r_ack = 0;
        step;
        chk("b_ld_ready", b_cpu.cpu_ready, 1);
        chk("b_ld_rdata", b_cpu.cpu_rdata, 32'hCAFE_F00D);
        step;

        b_cpu.cpu_req = 1; b_cpu.cpu_we = 1; b_cpu.cpu_addr = 32'h0000_0040;
        step;
        b_cpu.cpu_req = 0;
        n = 0;
        while (n < 100 && b_mem.mem_wr) begin n++; step; end
        chk("to_st_wr_cycles", n, 50);
        chk("to_st_ready", b_cpu.cpu_ready, 1);
        chk("to_st_err", b_cpu.cpu_err, 1);
        step;

        b_mem.mem_rdata = 32'hFFFF_FFFF;
        b_cpu.cpu_req = 1; b_cpu.cpu_we = 0; b_cpu.cpu_addr = 32'h0000_0024;
        step;
        b_cpu.cpu_req = 0;
        n = 0;
        while (n < 100 && b_mem.mem_rd) begin n++; step; end
        chk("to_ld_rd_cycles", n, 50);
        chk("to_ld_ready", b_cpu.cpu_ready, 1);
        chk("to_ld_err", b_cpu.cpu_err, 1);
        chk("to_ld_rdata", b_cpu.cpu_rdata, 32'hCAFE_F00D);
        step;

        // Ack edge lands in the same cycle the counter expires
        b_cpu.cpu_req = 1; b_cpu.cpu_we = 1; b_cpu.cpu_addr = 32'h0000_0028;
        step;
        b_cpu.cpu_req = 0;
        repeat (47) step;
        #4 b_mem.w_ack = 1;
        step; step;
        chk("tie_ready_early", b_cpu.cpu_ready, 0);
        chk("tie_wr_held", b_mem.mem_wr, 1);
        step;
        chk("tie_ready", b_cpu.cpu_ready, 1);
        chk("tie_err", b_cpu.cpu_err, 0);
        b_mem.w_ack = 0;
        repeat (3) step;

        // Reset in the middle of a store
        a_cpu.cpu_req = 1; a_cpu.cpu_we = 1;
        a_cpu.cpu_addr = 32'h0000_0400; a_cpu.cpu_wdata = 32'h0BAD_F00D;
        step;
        a_cpu.cpu_req = 0;
        chk("rmid_wr_before", a_mem.mem_wr, 1);
        #4 rst = 1'b0;
        #1;
        chk("rmid_wr", a_mem.mem_wr, 0);
        chk("rmid_addr", a_mem.mem_addr, 0);
        chk("rmid_wdata", a_mem.mem_wdata, 0);
        chk("rmid_rdata", a_cpu.cpu_rdata, 0);
        chk("rmid_ready", a_cpu.cpu_ready, 0);
        step; step;
        rst = 1'b1;
        seen = 0;
        repeat (6) begin step; if (a_cpu.cpu_ready || a_mem.mem_wr) seen++; end
        chk("rmid_quiet", seen, 0);

        a_cpu.cpu_req = 1; a_cpu.cpu_we = 1;
        a_cpu.cpu_addr = 32'h0000_0404; a_cpu.cpu_wdata = 32'h7777_8888;
        step;
        a_cpu.cpu_req = 0;
        chk("rpost_wr", a_mem.mem_wr, 1);
        chk("rpost_wdata", a_mem.mem_wdata, 32'h7777_8888);
        repeat (2) step;
        #4 a_mem.w_ack = 1;
        step; step;
        #4 a_mem.w_ack = 0;
        step;
        chk("rpost_ready", a_cpu.cpu_ready, 1);
        chk("rpost_err", a_cpu.cpu_err, 0);
        chk("rpost_wr_done", a_mem.mem_wr, 0);
        step;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
